// File: rtl/hall_call_panel_if.sv
// Service-report handshake between the elevator controller (master) and the
// hall call panel (slave).
interface hall_call_panel_if #(
  parameter int FLOOR_BITS = 4
);
  logic                  serve_valid;
  logic [FLOOR_BITS-1:0] serve_floor;
  logic                  serve_up;
  logic                  serve_down;
  logic                  serve_ack;

  modport master (
    output serve_valid, serve_floor, serve_up, serve_down,
    input  serve_ack
  );

  modport slave (
    input  serve_valid, serve_floor, serve_up, serve_down,
    output serve_ack
  );
endinterface

// File: rtl/hall_call_panel.sv
// Hall call panel: synchronizes and qualifies hall buttons into sticky up/down
// requests cleared by acked service reports. Define HALL_DEBOUNCE_EN for debounce counters.
module hall_call_panel #(
  parameter int NUM_FLOORS      = 10,
  parameter int FLOOR_BITS      = $clog2(NUM_FLOORS),
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [NUM_FLOORS-1:0] up_btn_i,
  input  logic [NUM_FLOORS-1:0] down_btn_i,
  hall_call_panel_if.slave      serve,
  output logic [NUM_FLOORS-1:0] upreq_o,
  output logic [NUM_FLOORS-1:0] downreq_o,
  output logic                  pending_o
);

  localparam int NB = 2 * NUM_FLOORS;
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("hall_call_panel: DEBOUNCE_CYCLES must be in 1..15");
  end

  logic [NB-1:0] btn;
  logic [NB-1:0] fire;

  assign btn = {down_btn_i, up_btn_i};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic s1_q;
      logic s2_q;
      logic armed_q;
      logic armed_d;
      logic qual;

`ifdef HALL_DEBOUNCE_EN
      logic [3:0] cnt_q;
      logic [3:0] cnt_d;

      assign qual = s2_q && (cnt_q == 4'(DEBOUNCE_CYCLES - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (!s2_q) begin
          cnt_d = 4'd0;
        end else if (cnt_q != 4'(DEBOUNCE_CYCLES)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (resetN) begin
          cnt_q <= 4'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
`else
      assign qual = s2_q;
`endif

      // A held button fires once; armed only returns once the synchronized level drops.
      always_comb begin
        armed_d = armed_q;
        if (!s2_q) begin
          armed_d = 1'b1;
        end else if (qual) begin
          armed_d = 1'b0;
        end
      end

      assign fire[gi] = qual && armed_q;

      always_ff @(posedge clk) begin
        if (resetN) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          armed_q <= 1'b1;
        end else begin
          s1_q    <= btn[gi];
          s2_q    <= s1_q;
          armed_q <= armed_d;
        end
      end
    end
  endgenerate

  logic                  take;
  logic                  ack_q;
  logic                  pending_q;
  logic [NUM_FLOORS-1:0] clr_up;
  logic [NUM_FLOORS-1:0] clr_dn;
  logic [NUM_FLOORS-1:0] upreq_q;
  logic [NUM_FLOORS-1:0] upreq_d;
  logic [NUM_FLOORS-1:0] downreq_q;
  logic [NUM_FLOORS-1:0] downreq_d;

  // A report is only taken when no ack is outstanding, so reports complete every other cycle at most.
  assign take = serve.serve_valid && !ack_q;

  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_clr
      logic hit;
      assign hit        = take && (serve.serve_floor == FLOOR_BITS'(gi));
      assign clr_up[gi] = hit && serve.serve_up;
      assign clr_dn[gi] = hit && serve.serve_down;
    end
  endgenerate

  always_comb begin
    upreq_d   = (upreq_q   | fire[NUM_FLOORS-1:0])  & ~clr_up & UP_MASK;
    downreq_d = (downreq_q | fire[NB-1:NUM_FLOORS]) & ~clr_dn & DN_MASK;
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      upreq_q   <= '0;
      downreq_q <= '0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      upreq_q   <= upreq_d;
      downreq_q <= downreq_d;
      ack_q     <= take;
      pending_q <= |(upreq_d | downreq_d);
    end
  end

  assign upreq_o         = upreq_q;
  assign downreq_o       = downreq_q;
  assign pending_o       = pending_q;
  assign serve.serve_ack = ack_q;

endmodule

// File: tb/tb_hall_call_panel.sv
// Self-checking bench for hall_call_panel: directed table, hand-written corner
// sequences and a randomized run against a run-length request model.
module tb_hall_call_panel;

  localparam int NF = 10;
  localparam int FB = 4;
  localparam int DB = 4;
`ifdef HALL_DEBOUNCE_EN
  localparam int DEFF = DB;
`else
  localparam int DEFF = 1;
`endif
  localparam int LAT = 2 + DEFF;

  logic          clk = 1'b0;
  logic          resetN;
  logic [NF-1:0] up_btn;
  logic [NF-1:0] dn_btn;
  logic [NF-1:0] upreq;
  logic [NF-1:0] downreq;
  logic          pending;

  int checks   = 0;
  int failures = 0;

  hall_call_panel_if #(.FLOOR_BITS(FB)) sif ();

  hall_call_panel #(
    .NUM_FLOORS     (NF),
    .FLOOR_BITS     (FB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .up_btn_i  (up_btn),
    .down_btn_i(dn_btn),
    .serve     (sif),
    .upreq_o   (upreq),
    .downreq_o (downreq),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_set(input logic v, input logic [FB-1:0] f, input logic su, input logic sd);
    sif.serve_valid = v;
    sif.serve_floor = f;
    sif.serve_up    = su;
    sif.serve_down  = sd;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    up_btn = '0;
    dn_btn = '0;
    serve_set(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    resetN = 1'b0;
  endtask

  typedef struct {
    logic [NF-1:0] up_press;
    logic [NF-1:0] dn_press;
    logic [FB-1:0] floor;
    logic          su;
    logic          sd;
    logic [NF-1:0] exp_up;
    logic [NF-1:0] exp_dn;
  } vec_t;

  vec_t tbl[5];

  // Reference model state
  logic [2*NF-1:0] hist[$];
  int              run[2*NF];
  logic [NF-1:0]   m_up;
  logic [NF-1:0]   m_dn;
  logic            m_ack;
  logic            m_pend;

  task automatic model_step();
    logic [2*NF-1:0] sync;
    logic [2*NF-1:0] fire;
    logic [NF-1:0]   nu;
    logic [NF-1:0]   nd;
    logic            take;
    if (resetN) begin
      hist.delete();
      hist.push_front('0);
      hist.push_front('0);
      for (int i = 0; i < 2*NF; i++) run[i] = 0;
      m_up = '0; m_dn = '0; m_ack = 1'b0; m_pend = 1'b0;
    end else begin
      hist.push_front({dn_btn, up_btn});
      sync = hist[2];
      void'(hist.pop_back());
      for (int i = 0; i < 2*NF; i++) begin
        if (sync[i]) run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
        else run[i] = 0;
        fire[i] = sync[i] && (run[i] == DEFF);
      end
      take = sif.serve_valid && !m_ack;
      nu = m_up | fire[NF-1:0];
      nd = m_dn | fire[2*NF-1:NF];
      if (take && (int'(sif.serve_floor) < NF)) begin
        if (sif.serve_up)   nu[sif.serve_floor] = 1'b0;
        if (sif.serve_down) nd[sif.serve_floor] = 1'b0;
      end
      nu[NF-1] = 1'b0;
      nd[0]    = 1'b0;
      m_up = nu; m_dn = nd; m_pend = |{nu, nd}; m_ack = take;
    end
  endtask

  initial begin
    int acks;
    int rises;
    logic prev;

    tbl[0] = '{10'h004, 10'h004, 4'd2,  1'b1, 1'b0, 10'h000, 10'h004};
    tbl[1] = '{10'h201, 10'h001, 4'd12, 1'b1, 1'b1, 10'h001, 10'h000};
    tbl[2] = '{10'h3FF, 10'h3FF, 4'd5,  1'b1, 1'b1, 10'h1DF, 10'h3DE};
    tbl[3] = '{10'h010, 10'h200, 4'd9,  1'b0, 1'b1, 10'h010, 10'h000};
    tbl[4] = '{10'h010, 10'h000, 4'd4,  1'b0, 1'b0, 10'h010, 10'h000};

    // Reset with every button pressed, then press latency
    resetN = 1'b1;
    up_btn = '1;
    dn_btn = '1;
    serve_set(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_upreq",   32'(upreq),   32'h0);
    chk("reset_downreq", 32'(downreq), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_ack",     32'(sif.serve_ack), 32'h0);
    resetN = 1'b0;
    up_btn = 10'h008;
    dn_btn = '0;
    repeat (LAT - 1) tick();
    chk("latency_early_up",      32'(upreq),   32'h0);
    chk("latency_early_pending", 32'(pending), 32'h0);
    tick();
    chk("latency_up",      32'(upreq),   32'h008);
    chk("latency_pending", 32'(pending), 32'h1);

    // Short pulse on down_btn[5]
    do_reset();
    dn_btn = 10'h020;
    repeat (3) tick();
    dn_btn = '0;
    repeat (8) tick();
    chk("glitch_down5", 32'(downreq), (DEFF > 3) ? 32'h0 : 32'h020);

    // Held button fires once; service while held does not re-latch
    do_reset();
    dn_btn = 10'h020;
    rises = 0;
    prev = 1'b0;
    repeat (20) begin
      tick();
      if (downreq[5] && !prev) rises++;
      prev = downreq[5];
    end
    chk("hold_down5",       32'(downreq), 32'h020);
    chk("hold_single_fire", 32'(rises),   32'd1);
    serve_set(1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    chk("held_serve_ack",  32'(sif.serve_ack), 32'h1);
    chk("held_serve_down", 32'(downreq), 32'h0);
    serve_set(1'b0, '0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("held_no_refire", 32'(downreq), 32'h0);
    dn_btn = '0;
    repeat (3) tick();
    dn_btn = 10'h020;
    repeat (LAT) tick();
    chk("repress_down5", 32'(downreq), 32'h020);
    dn_btn = '0;

    // Service of one direction and back-to-back acks
    do_reset();
    up_btn = 10'h004;
    dn_btn = 10'h004;
    repeat (LAT) tick();
    up_btn = '0;
    dn_btn = '0;
    tick();
    serve_set(1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    chk("serve2_up",   32'(upreq),   32'h0);
    chk("serve2_down", 32'(downreq), 32'h004);
    chk("serve2_ack",  32'(sif.serve_ack), 32'h1);
    serve_set(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("serve2_ack_drop", 32'(sif.serve_ack), 32'h0);
    serve_set(1'b1, 4'd2, 1'b1, 1'b0);
    acks = 0;
    repeat (4) begin
      tick();
      if (sif.serve_ack) acks++;
    end
    serve_set(1'b0, '0, 1'b0, 1'b0);
    chk("held_valid_acks", 32'(acks), 32'd2);
    tick();

    // Press qualifying on the same edge as service of that request
    do_reset();
    up_btn = 10'h010;
    repeat (LAT - 1) tick();
    serve_set(1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    chk("setclr_ack", 32'(sif.serve_ack), 32'h1);
    chk("setclr_up4", 32'(upreq), 32'h0);
    serve_set(1'b0, '0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("setclr_no_relatch", 32'(upreq), 32'h0);
    up_btn = '0;

    // Table-driven press/serve vectors
    for (int v = 0; v < 5; v++) begin
      do_reset();
      up_btn = tbl[v].up_press;
      dn_btn = tbl[v].dn_press;
      repeat (LAT + 1) tick();
      up_btn = '0;
      dn_btn = '0;
      repeat (3) tick();
      serve_set(1'b1, tbl[v].floor, tbl[v].su, tbl[v].sd);
      tick();
      chk($sformatf("tbl%0d_ack", v), 32'(sif.serve_ack), 32'h1);
      serve_set(1'b0, '0, 1'b0, 1'b0);
      tick();
      chk($sformatf("tbl%0d_up", v),   32'(upreq),   32'(tbl[v].exp_up));
      chk($sformatf("tbl%0d_down", v), 32'(downreq), 32'(tbl[v].exp_dn));
      chk($sformatf("tbl%0d_pending", v), 32'(pending), 32'(|{tbl[v].exp_up, tbl[v].exp_dn}));
    end

    // Randomized run against the reference model, with occasional resets
    resetN = 1'b1;
    up_btn = '0;
    dn_btn = '0;
    serve_set(1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("rand_upreq",   32'(upreq),   32'(m_up));
      chk("rand_downreq", 32'(downreq), 32'(m_dn));
      chk("rand_ack",     32'(sif.serve_ack), 32'(m_ack));
      chk("rand_pending", 32'(pending), 32'(m_pend));
      resetN = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 23) == 0) up_btn[i] = ~up_btn[i];
        if ($urandom_range(0, 23) == 0) dn_btn[i] = ~dn_btn[i];
      end
      serve_set($urandom_range(0, 3) == 0, FB'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Hall-side request generator for the elevator controller: it drives the `upreq`/`downreq` vectors that the request resolver consumes. The block synchronizes and debounces the raw hall push-buttons, latches each valid press as a sticky request, and clears requests when the controller reports service at a floor. Service is reported through a valid/ack handshake. The latched vectors also drive the hall-button lamps.

## Interface
- `NUM_FLOORS`, default 10: number of floors.
- `FLOOR_BITS`, default `$clog2(NUM_FLOORS)`: width of a floor index.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized-high samples that qualify a press (range 1..15).
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `resetN`  input  1  synchronous, active-high reset (asserted = 1 resets the block at the next `clk` edge).
- `up_btn`  input  NUM_FLOORS  raw hall "up" buttons, asynchronous, 1 = pressed.
- `down_btn`  input  NUM_FLOORS  raw hall "down" buttons, asynchronous, 1 = pressed.
- `serve_valid`  input  1  controller reports service at `serve_floor`.
- `serve_floor`  input  FLOOR_BITS  floor being served.
- `serve_up`, `serve_down`  input  1 each  select which direction request(s) to clear.
- `serve_ack`  output  1  one-cycle acknowledge of a service report.
- `upreq`  output  NUM_FLOORS  latched up requests (also drive the lamps).
- `downreq`  output  NUM_FLOORS  latched down requests.
- `pending`  output  1  registered OR of all request bits.

## Operation
- **Per-button input path (2·NUM_FLOORS instances):**
  - 2-flop synchronizer `s1` → `s2`.
  - Debounce counter `cnt` saturating at `DEBOUNCE_CYCLES`; reset to 0 whenever `s2` = 0.
  - `armed` flag.
- **Qualification:** `s2` = 1 and `cnt` = `DEBOUNCE_CYCLES`−1 at a clock edge.
  - If `armed` is set, the request bit sets and `armed` clears at that edge.
  - `armed` sets again at any edge where `s2` = 0. One press therefore yields one request, and a held button never re-fires.
- **Invalid buttons:** `downreq[0]` and `upreq[NUM_FLOORS-1]` are constant 0, and their button inputs are ignored.
- **Request bits** are sticky until cleared by service or reset. Pressing an already-set request has no effect.
- **Service handshake:**
  - When `serve_valid` = 1 and `serve_ack` = 0 are sampled at an edge, that same edge:
    - clears `upreq[serve_floor]` if `serve_up` = 1;
    - clears `downreq[serve_floor]` if `serve_down` = 1;
    - sets `serve_ack` = 1 for exactly one cycle.
  - While `serve_ack` = 1, `serve_valid` is ignored. A still-high `serve_valid` in the cycle after the ack is a new report, so reports complete at most one every 2 cycles.
  - If `serve_floor` ≥ `NUM_FLOORS`, nothing is cleared but the report is still acked.
  - If both `serve_up` and `serve_down` are 0, the report is acked and nothing is cleared.
- **Set and clear on the same bit in the same edge:** the clear wins and the press is consumed. `armed` still clears, so the press is not re-latched.
- **`pending`** is registered from the next-state request vectors, so it changes on the same edge as `upreq`/`downreq`.

## Timing
- **Reset:** `upreq`, `downreq`, `serve_ack` and `pending` are 0 after the reset edge. Also after that edge:
  - `s1`, `s2` and `cnt` are 0;
  - `armed` is 1.
- **Reset mid-operation:** an in-flight debounce or service report is discarded. A report held through reset is acked one cycle after the first non-reset edge.
- **Press latency:** the button is high before edge 1; `s2` = 1 after edge 2; the request bit is visible after edge 2+`DEBOUNCE_CYCLES`. With the default value this is 6 cycles.
- **Glitch rejection:** a high pulse shorter than `DEBOUNCE_CYCLES` synchronized samples produces no request.
- **Service latency:** the clear and `serve_ack` are visible 1 cycle after `serve_valid` is sampled.

## Configuration
- **`HALL_DEBOUNCE_EN` defined:** counters are present and behave as described above.
- **`HALL_DEBOUNCE_EN` not defined:**
  - Counters are removed; qualification is `s2` = 1 with `armed` = 1.
  - Press latency is a fixed 3 cycles, and any synchronized pulse registers.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold `resetN` = 1 for 2 cycles with all buttons pressed → all outputs 0. Release `resetN` and hold `up_btn[3]` high → `upreq[3]` = 1 exactly 6 cycles later (3 cycles without the macro), and `pending` = 1 on the same edge.
- **Glitch and single fire:** 3-cycle pulse on `down_btn[5]` → no request. Hold `down_btn[5]` for 20 cycles → `downreq[5]` sets once. Clear it by service while the button is still held → it stays 0 until the button is released and pressed again.
- **Service clears:** with `upreq[2]` and `downreq[2]` set, send `serve_valid` with `serve_floor` = 2, `serve_up` = 1 → next cycle `upreq[2]` = 0, `downreq[2]` = 1, `serve_ack` high for 1 cycle. `serve_valid` held 4 cycles → exactly 2 acks.
- **Simultaneous set and clear:** press `up_btn[4]` timed so it qualifies on the same edge as service of floor 4 up → `upreq[4]` stays 0.
- **Invalid inputs:** press `down_btn[0]` and `up_btn[9]` → both requests stay 0. Serve with `serve_floor` = 12 → acked, all requests unchanged.
